sprite_stream: RTL and testbench

- Parametrised sprite texture engine that replaces the combinational bitmap lookup with a request/stream interface.
- Holds several page-packed monochrome sprites in a synchronous ROM, with a per-sprite descriptor (base, width in columns, height in 8-pixel pages).
- On request, streams one sprite's bytes to the display writer in page-major, column-minor order, with valid/ready back-pressure.
- Optional horizontal mirror and colour invert are applied per request.

---
 rtl/sprite_pkg.sv | 48 ++++
 rtl/sprite_stream_rom.sv | 30 +++
 rtl/sprite_stream.sv | 158 +++++++++++++++
 tb/tb_sprite_stream.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types, widths, sprite descriptors and ROM contents for the sprite engine.
package sprite_pkg;

  localparam int ADDR_W_P      = 10;
  localparam int DATA_W_P      = 8;
  localparam int NUM_SPRITES_P = 4;
  localparam int SID_W_P       = 2;
  localparam int COL_W_P       = 7;
  localparam int PAGE_W_P      = 3;

  // Engine states: ISSUE presents the ROM address, DATA holds the registered byte.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DATA  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W_P-1:0] base;
    logic [COL_W_P-1:0]  width;
    logic [PAGE_W_P-1:0] pages;
  } sprite_desc_t;

  localparam int SPR_REX    = 0;
  localparam int SPR_CACTUS = 1;

  // Entry 2 is deliberately degenerate (zero width) and must be rejected.
  localparam sprite_desc_t SPRITE_DESC [NUM_SPRITES_P] = '{
    '{base: 10'd0,  width: 7'd23, pages: 3'd3},
    '{base: 10'd69, width: 7'd8,  pages: 3'd2},
    '{base: 10'd85, width: 7'd0,  pages: 3'd2},
    '{base: 10'd85, width: 7'd4,  pages: 3'd1}
  };

  // ROM image: a few pinned bytes of the rex bitmap, the rest a fixed scramble.
  function automatic logic [7:0] rom_byte(input int unsigned addr);
    logic [7:0] b;
    case (addr)
      0:       b = 8'h01;
      13:      b = 8'h87;
      22:      b = 8'hce;
      68:      b = 8'hf8;
      default: b = 8'((addr * 32'd37 + 32'd11) ^ (addr >> 3));
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sprite_stream_rom.sv
// Synchronous sprite ROM: one cycle from address to registered data, no reset on data.
module sprite_rom
  import sprite_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_P,
  parameter int DATA_W = DATA_W_P
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] data_q;

  genvar gi;
  generate
    for (gi = 0; gi < 2**ADDR_W; gi++) begin : g_rom
      assign mem[gi] = DATA_W'(rom_byte(gi));
    end
  endgenerate

  // Registered read so the array maps onto block ROM.
  always_ff @(posedge clk) begin
    data_q <= mem[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/sprite_stream.sv
// Sprite texture engine: streams one sprite page-major/column-minor with valid/ready.
module sprite_stream
  import sprite_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_P,
  parameter int DATA_W      = DATA_W_P,
  parameter int NUM_SPRITES = NUM_SPRITES_P,
  parameter int SID_W       = SID_W_P,
  parameter int COL_W       = COL_W_P,
  parameter int PAGE_W      = PAGE_W_P
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [SID_W-1:0]  req_sid,
  input  logic              req_mirror,
  input  logic              req_invert,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [COL_W-1:0]  out_col,
  output logic [PAGE_W-1:0] out_page,
  output logic              out_last,
  output logic              err
);

  state_t             state_q, state_d;
  logic [COL_W-1:0]   width_q, width_d;
  logic [PAGE_W-1:0]  pages_q, pages_d;
  logic               mirror_q, mirror_d;
  logic               invert_q, invert_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [PAGE_W-1:0]  page_q, page_d;
  logic [ADDR_W-1:0]  row_base_q, row_base_d;  // base + page*width, kept as a running sum
  logic               err_q, err_d;

  sprite_desc_t       desc_sel;
  logic               sid_ok;
  logic               desc_ok;
  logic               last_col;
  logic               last_byte;
  logic [COL_W-1:0]   col_eff;
  logic [ADDR_W-1:0]  rom_addr;
  logic [DATA_W-1:0]  rom_data;

  // Descriptor lookup; ids beyond the table and empty sprites are both rejected.
  always_comb begin
    desc_sel = '0;
    sid_ok   = (int'(req_sid) < NUM_SPRITES);
    if (sid_ok) begin
      desc_sel = SPRITE_DESC[req_sid];
    end
    desc_ok = sid_ok && (desc_sel.width != '0) && (desc_sel.pages != '0);
  end

  assign last_col  = (col_q == width_q - COL_W'(1));
  assign last_byte = last_col && (page_q == pages_q - PAGE_W'(1));

  // Mirroring only changes which ROM byte is fetched; the reported column stays left-to-right.
  assign col_eff  = mirror_q ? (width_q - COL_W'(1) - col_q) : col_q;
  assign rom_addr = row_base_q + ADDR_W'(col_eff);

  sprite_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rom (
    .clk    (clk),
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  // State and datapath registers; reset abandons any stream in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      width_q    <= '0;
      pages_q    <= '0;
      mirror_q   <= 1'b0;
      invert_q   <= 1'b0;
      col_q      <= '0;
      page_q     <= '0;
      row_base_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      pages_q    <= pages_d;
      mirror_q   <= mirror_d;
      invert_q   <= invert_d;
      col_q      <= col_d;
      page_q     <= page_d;
      row_base_q <= row_base_d;
      err_q      <= err_d;
    end
  end

  // Next-state: accept in IDLE, one fetch cycle, then hold the byte until it is taken.
  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    pages_d    = pages_q;
    mirror_d   = mirror_q;
    invert_d   = invert_q;
    col_d      = col_q;
    page_d     = page_q;
    row_base_d = row_base_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (desc_ok) begin
            width_d    = COL_W'(desc_sel.width);
            pages_d    = PAGE_W'(desc_sel.pages);
            row_base_d = ADDR_W'(desc_sel.base);
            mirror_d   = req_mirror;
            invert_d   = req_invert;
            col_d      = '0;
            page_d     = '0;
            state_d    = S_ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_DATA;
      end
      S_DATA: begin
        if (out_ready) begin
          if (last_byte) begin
            state_d = S_IDLE;
          end else if (last_col) begin
            col_d      = '0;
            page_d     = page_q + PAGE_W'(1);
            row_base_d = row_base_q + ADDR_W'(width_q);
            state_d    = S_ISSUE;
          end else begin
            col_d   = col_q + COL_W'(1);
            state_d = S_ISSUE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DATA);
  assign out_data  = out_valid ? (invert_q ? ~rom_data : rom_data) : '0;
  assign out_col   = out_valid ? col_q : '0;
  assign out_page  = out_valid ? page_q : '0;
  assign out_last  = out_valid && last_byte;
  assign err       = err_q;

endmodule

// File: tb/tb_sprite_stream.sv
// Directed bench for sprite_stream with a scoreboard of expected bytes.
module tb_sprite_stream;
  import sprite_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_sid;
  logic       req_mirror;
  logic       req_invert;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [6:0] out_col;
  logic [2:0] out_page;
  logic       out_last;
  logic       err;

  typedef struct {
    logic [7:0] data;
    logic [6:0] col;
    logic [2:0] page;
    logic       last;
  } exp_t;

  exp_t       sb_q [$];
  logic [7:0] rx_data [$];
  logic [6:0] rx_col  [$];
  logic [7:0] plain_data [$];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  sprite_stream #(
    .NUM_SPRITES (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sid    (req_sid),
    .req_mirror (req_mirror),
    .req_invert (req_invert),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_col    (out_col),
    .out_page   (out_page),
    .out_last   (out_last),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected stream straight from the descriptor table and ROM image.
  task automatic push_expected(input int sid, input bit mir, input bit inv);
    sprite_desc_t d;
    exp_t e;
    int w, pg, a;
    d  = SPRITE_DESC[sid];
    w  = int'(d.width);
    pg = int'(d.pages);
    for (int p = 0; p < pg; p++) begin
      for (int c = 0; c < w; c++) begin
        a = int'(d.base) + p * w + (mir ? (w - 1 - c) : c);
        e.data = rom_byte(a) ^ (inv ? 8'hff : 8'h00);
        e.col  = 7'(c);
        e.page = 3'(p);
        e.last = (p == pg - 1) && (c == w - 1);
        sb_q.push_back(e);
      end
    end
  endtask

  // Issue a valid request at a negedge; returns at the negedge after acceptance.
  task automatic do_request(input int sid, input bit mir, input bit inv);
    req_sid    = 2'(sid);
    req_mirror = mir;
    req_invert = inv;
    req_valid  = 1'b1;
    check("req_ready_before_accept", 32'(req_ready), 32'd1);
    push_expected(sid, mir, inv);
    @(negedge clk);
    req_valid = 1'b0;
    check("issue_cycle_no_valid", 32'(out_valid), 32'd0);
    check("busy_not_ready", 32'(req_ready), 32'd0);
  endtask

  // Drain n bytes, checking order, latency and stability under back-pressure.
  task automatic consume(input bit bp, input int n);
    int   got = 0;
    int   cyc = 0;
    bit   first = 1'b1;
    bit   held_v = 1'b0;
    exp_t held;
    exp_t e;
    rx_data.delete();
    rx_col.delete();
    while (got < n && cyc < 4000) begin
      @(negedge clk);
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held_v) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data",  32'(out_data),  32'(held.data));
        check("stall_col",   32'(out_col),   32'(held.col));
        check("stall_page",  32'(out_page),  32'(held.page));
        check("stall_last",  32'(out_last),  32'(held.last));
      end
      held_v = 1'b0;
      if (out_valid) begin
        if (first) begin
          check("first_byte_latency", 32'(cyc), 32'd0);
          first = 1'b0;
        end
        if (out_ready) begin
          if (sb_q.size() == 0) begin
            check("scoreboard_underflow", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("byte_data", 32'(out_data), 32'(e.data));
            check("byte_col",  32'(out_col),  32'(e.col));
            check("byte_page", 32'(out_page), 32'(e.page));
            check("byte_last", 32'(out_last), 32'(e.last));
          end
          rx_data.push_back(out_data);
          rx_col.push_back(out_col);
          got++;
        end else begin
          held.data = out_data;
          held.col  = out_col;
          held.page = out_page;
          held.last = out_last;
          held_v    = 1'b1;
        end
      end
      cyc++;
    end
    check("stream_byte_count", 32'(got), 32'(n));
    out_ready = 1'b1;
  endtask

  // After a complete stream the engine must be idle and silent.
  task automatic expect_idle(input string tag);
    @(negedge clk);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_queue_empty"}, 32'(sb_q.size()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_no_extra_valid"}, 32'(out_valid), 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic bad_request(input int sid, input string tag);
    req_sid   = 2'(sid);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_err_pulse"}, 32'(err), 32'd1);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_no_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_err_cleared"}, 32'(err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_still_no_valid"}, 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_sid    = '0;
    req_mirror = 1'b0;
    req_invert = 1'b0;
    out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data",  32'(out_data),  32'd0);
    check("reset_out_last",  32'(out_last),  32'd0);
    check("reset_err",       32'(err),       32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'd1);

    // Plain stream of the rex sprite.
    do_request(SPR_REX, 1'b0, 1'b0);
    consume(1'b0, 69);
    $display("plain stream: %0d bytes received", rx_data.size());
    check("plain_first_byte", 32'(rx_data[0]), 32'h01);
    check("plain_byte14", 32'(rx_data[13]), 32'h87);
    check("plain_last_byte", 32'(rx_data[68]), 32'hf8);
    plain_data = rx_data;
    expect_idle("plain");

    // Mirrored.
    do_request(SPR_REX, 1'b1, 1'b0);
    consume(1'b0, 69);
    $display("mirror stream: %0d bytes received", rx_data.size());
    check("mirror_first_byte", 32'(rx_data[0]), 32'hce);
    check("mirror_first_col", 32'(rx_col[0]), 32'd0);
    check("mirror_byte23", 32'(rx_data[22]), 32'h01);
    check("mirror_byte23_col", 32'(rx_col[22]), 32'd22);
    expect_idle("mirror");

    // Inverted.
    do_request(SPR_REX, 1'b0, 1'b1);
    consume(1'b0, 69);
    $display("invert stream: %0d bytes received", rx_data.size());
    check("invert_first_byte", 32'(rx_data[0]), 32'hfe);
    check("invert_last_byte", 32'(rx_data[68]), 32'h07);
    expect_idle("invert");

    // Random back-pressure must not alter the sequence.
    do_request(SPR_REX, 1'b0, 1'b0);
    consume(1'b1, 69);
    $display("backpressure stream: %0d bytes received", rx_data.size());
    for (int i = 0; i < 69; i++) begin
      check("bp_matches_plain", 32'(rx_data[i]), 32'(plain_data[i]));
    end
    expect_idle("bp");

    // Second sprite, both modifiers, with back-pressure.
    do_request(SPR_CACTUS, 1'b1, 1'b1);
    consume(1'b1, 16);
    $display("cactus stream: %0d bytes received", rx_data.size());
    expect_idle("cactus");

    // Out-of-range id and degenerate descriptor.
    bad_request(3, "sid_oob");
    $display("invalid sid 3 request done");
    bad_request(2, "sid_empty");
    $display("degenerate sid 2 request done");

    // Reset in the middle of a stream.
    do_request(SPR_REX, 1'b0, 1'b0);
    consume(1'b0, 10);
    @(negedge clk);
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_out_data",  32'(out_data),  32'd0);
    check("midreset_out_col",   32'(out_col),   32'd0);
    check("midreset_out_page",  32'(out_page),  32'd0);
    check("midreset_out_last",  32'(out_last),  32'd0);
    sb_q.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("midreset_ready", 32'(req_ready), 32'd1);
    check("midreset_still_idle", 32'(out_valid), 32'd0);
    $display("reset mid-stream after 10 bytes");
    do_request(SPR_REX, 1'b0, 1'b0);
    consume(1'b0, 69);
    $display("restart stream: %0d bytes received", rx_data.size());
    check("restart_first_byte", 32'(rx_data[0]), 32'h01);
    check("restart_first_col", 32'(rx_col[0]), 32'd0);
    expect_idle("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
